// File: rtl/nn_infer_sequencer_pkg.sv
// Shared types and default sizing for the binary-NN inference sequencer.
// The state names mirror the image lifecycle: load pixels, run hidden layer, run output layer, report.
package nn_infer_sequencer_pkg;

  localparam int N_IN_DEF  = 784;
  localparam int N_HID_DEF = 32;
  localparam int N_OUT_DEF = 10;
  localparam int ACC_W_DEF = 16;

  localparam int NEURON_W = 6;
  localparam int PRED_W   = 4;

  typedef enum logic [2:0] {
    LOAD      = 3'd0,
    HID_ISSUE = 3'd1,
    HID_WAIT  = 3'd2,
    OUT_ISSUE = 3'd3,
    OUT_WAIT  = 3'd4,
    DONE      = 3'd5
  } seqState_e;

  // Ties must keep the earlier class, so only a strictly larger score may displace the incumbent.
  function automatic logic beats(input logic signed [ACC_W_DEF-1:0] challenger,
                                 input logic signed [ACC_W_DEF-1:0] incumbent);
    return challenger > incumbent;
  endfunction

endpackage

// File: rtl/nn_infer_sequencer_argmax_tracker.sv
// Running argmax over the output-layer scores of one image.
// Index 0 always seeds the running best, so no stale score from a previous image can win.
module nn_argmax_tracker
  import nn_infer_sequencer_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [PRED_W-1:0]       idx,
  input  logic signed [ACC_W-1:0] score,
  output logic [PRED_W-1:0]       best_idx
);

  logic signed [ACC_W-1:0] bestScore_q, bestScore_d;
  logic [PRED_W-1:0]       bestIdx_q, bestIdx_d;
  logic                    greater;

  always_comb begin
    greater = score > bestScore_q;
    bestScore_d = bestScore_q;
    bestIdx_d   = bestIdx_q;
    if (en && ((idx == '0) || greater)) begin
      bestScore_d = score;
      bestIdx_d   = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bestScore_q <= '0;
      bestIdx_q   <= '0;
    end else begin
      bestScore_q <= bestScore_d;
      bestIdx_q   <= bestIdx_d;
    end
  end

  assign best_idx = bestIdx_q;

endmodule

// File: rtl/nn_infer_sequencer.sv
// Control FSM for the MNIST binary NN: deserialises one image, walks the MAC engine over the hidden
// and output layers, binarises hidden scores and reports the argmax class with a one-cycle valid.
module nn_infer_sequencer
  import nn_infer_sequencer_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_HID = N_HID_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [N_IN-1:0]         pixels,
  output logic [N_HID-1:0]        hid_act,
  output logic                    mac_start,
  output logic                    mac_layer,
  output logic [NEURON_W-1:0]     mac_neuron,
  input  logic                    mac_done,
  input  logic signed [ACC_W-1:0] mac_score,
  output logic [PRED_W-1:0]       prediction,
  output logic                    valid_out
);

  localparam int PIX_W  = $clog2(N_IN);
  localparam int HID_IW = $clog2(N_HID);

  localparam logic [PIX_W-1:0]    LAST_PIX = PIX_W'(N_IN - 1);
  localparam logic [NEURON_W-1:0] LAST_HID = NEURON_W'(N_HID - 1);
  localparam logic [NEURON_W-1:0] LAST_OUT = NEURON_W'(N_OUT - 1);

  seqState_e             state_q;
  logic [PIX_W-1:0]      pixCnt_q;
  logic [NEURON_W-1:0]   neuron_q;
  logic [N_IN-1:0]       pixels_q;
  logic [N_HID-1:0]      hidAct_q;
  logic                  macStart_q;
  logic                  macLayer_q;
  logic [PRED_W-1:0]     prediction_q;
  logic                  valid_q;
  logic                  dataReady_q;

  logic [HID_IW-1:0]     hidIdx;
  logic                  trackEn;
  logic                  trackClr;
  logic [PRED_W-1:0]     bestIdx;

  assign hidIdx   = neuron_q[HID_IW-1:0];
  assign trackEn  = (state_q == OUT_WAIT) && mac_done;
  assign trackClr = (state_q == DONE);

  nn_argmax_tracker #(
    .ACC_W (ACC_W)
  ) u_argmax (
    .clk      (clk),
    .rst      (rst),
    .clr      (trackClr),
    .en       (trackEn),
    .idx      (neuron_q[PRED_W-1:0]),
    .score    (mac_score),
    .best_idx (bestIdx)
  );

  // mac_start is raised on the transition into an ISSUE state, so it is high exactly while in it;
  // mac_done is only honoured in a WAIT state, which also drops one coinciding with mac_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      pixCnt_q     <= '0;
      neuron_q     <= '0;
      pixels_q     <= '0;
      hidAct_q     <= '0;
      macStart_q   <= 1'b0;
      macLayer_q   <= 1'b0;
      prediction_q <= '0;
      valid_q      <= 1'b0;
      dataReady_q  <= 1'b1;
    end else begin
      macStart_q <= 1'b0;
      valid_q    <= 1'b0;
      unique case (state_q)
        LOAD: begin
          if (data_valid && dataReady_q) begin
            pixels_q[pixCnt_q] <= data_in;
            if (pixCnt_q == LAST_PIX) begin
              pixCnt_q    <= '0;
              dataReady_q <= 1'b0;
              macStart_q  <= 1'b1;
              state_q     <= HID_ISSUE;
            end else begin
              pixCnt_q <= pixCnt_q + 1'b1;
            end
          end
        end
        HID_ISSUE: state_q <= HID_WAIT;
        HID_WAIT: begin
          if (mac_done) begin
            hidAct_q[hidIdx] <= ~mac_score[ACC_W-1];
            macStart_q       <= 1'b1;
            if (neuron_q == LAST_HID) begin
              neuron_q   <= '0;
              macLayer_q <= 1'b1;
              state_q    <= OUT_ISSUE;
            end else begin
              neuron_q <= neuron_q + 1'b1;
              state_q  <= HID_ISSUE;
            end
          end
        end
        OUT_ISSUE: state_q <= OUT_WAIT;
        OUT_WAIT: begin
          if (mac_done) begin
            if (neuron_q == LAST_OUT) begin
              neuron_q <= '0;
              state_q  <= DONE;
            end else begin
              neuron_q   <= neuron_q + 1'b1;
              macStart_q <= 1'b1;
              state_q    <= OUT_ISSUE;
            end
          end
        end
        DONE: begin
          prediction_q <= bestIdx;
          valid_q      <= 1'b1;
          macLayer_q   <= 1'b0;
          dataReady_q  <= 1'b1;
          pixCnt_q     <= '0;
          state_q      <= LOAD;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign data_ready = dataReady_q;
  assign pixels     = pixels_q;
  assign hid_act    = hidAct_q;
  assign mac_start  = macStart_q;
  assign mac_layer  = macLayer_q;
  assign mac_neuron = neuron_q;
  assign prediction = prediction_q;
  assign valid_out  = valid_q;

endmodule

// File: tb/tb_nn_infer_sequencer.sv
// Bench for nn_infer_sequencer: random images and MAC scores, checked against an argmax/sign model.
module tb_nn_infer_sequencer;
  import nn_infer_sequencer_pkg::*;

  localparam int NIN  = 784;
  localparam int NHID = 32;
  localparam int NOUT = 10;
  localparam int ACCW = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   dataIn = 1'b0;
  logic                   dataValid = 1'b0;
  logic                   dataReady;
  logic [NIN-1:0]         pixels;
  logic [NHID-1:0]        hidAct;
  logic                   macStart;
  logic                   macLayer;
  logic [5:0]             macNeuron;
  logic                   macDone = 1'b0;
  logic signed [ACCW-1:0] macScore = '0;
  logic [3:0]             prediction;
  logic                   validOut;

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  logic signed [ACCW-1:0] hidScores[NHID];
  logic signed [ACCW-1:0] outScores[NOUT];

  bit macEnable = 1'b1;
  int injectReq = 0;
  int injectAck = 0;
  int hidStarts = 0;
  int outStarts = 0;
  int holdViolations = 0;
  int lastOutDoneCycle = -1;
  int validCount = 0;

  int             mdDelay;
  logic           mdLayer;
  logic [5:0]     mdNeuron;
  logic [NIN-1:0] curImg;

  nn_infer_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (dataIn),
    .data_valid (dataValid),
    .data_ready (dataReady),
    .pixels     (pixels),
    .hid_act    (hidAct),
    .mac_start  (macStart),
    .mac_layer  (macLayer),
    .mac_neuron (macNeuron),
    .mac_done   (macDone),
    .mac_score  (macScore),
    .prediction (prediction),
    .valid_out  (validOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // MAC engine model: answers each mac_start after 1-3 cycles with the score table entry
  always begin
    @(posedge clk); #1;
    macDone = 1'b0;
    if (injectReq != injectAck) begin
      injectAck = injectReq;
      macDone   = 1'b1;
      macScore  = 16'sh7fff;
    end else if (macStart && macEnable && !rst) begin
      mdLayer  = macLayer;
      mdNeuron = macNeuron;
      if (mdLayer) outStarts++; else hidStarts++;
      mdDelay = int'($urandom_range(1, 3));
      repeat (mdDelay) begin @(posedge clk); #1; end
      if (macEnable && (macNeuron !== mdNeuron || macLayer !== mdLayer)) holdViolations++;
      macDone  = 1'b1;
      macScore = mdLayer ? outScores[int'(mdNeuron) % NOUT] : hidScores[int'(mdNeuron) % NHID];
      if (mdLayer && int'(mdNeuron) == NOUT - 1) lastOutDoneCycle = cycle;
    end
  end

  always @(negedge clk) if (validOut === 1'b1) validCount++;

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic int expectedClass();
    int best = 0;
    for (int k = 1; k < NOUT; k++) if (int'(outScores[k]) > int'(outScores[best])) best = k;
    return best;
  endfunction

  function automatic logic [NHID-1:0] expectedHidden();
    logic [NHID-1:0] h;
    for (int j = 0; j < NHID; j++) h[j] = (int'(hidScores[j]) >= 0);
    return h;
  endfunction

  function automatic int bitDiff(input logic [NIN-1:0] a, input logic [NIN-1:0] b);
    int d = 0;
    for (int i = 0; i < NIN; i++) if (a[i] !== b[i]) d++;
    return d;
  endfunction

  task automatic randomHidden();
    for (int j = 0; j < NHID; j++) hidScores[j] = ACCW'(int'($urandom_range(0, 400)) - 200);
  endtask

  task automatic randomOutput(input int lo, input int hi);
    for (int k = 0; k < NOUT; k++) outScores[k] = ACCW'(int'($urandom_range(0, hi - lo)) + lo);
  endtask

  task automatic streamImage(input bit gaps);
    int idx = 0;
    int budget = 0;
    for (int i = 0; i < NIN; i++) curImg[i] = 1'($urandom);
    while (idx < NIN && budget < 20000) begin
      dataValid = gaps ? 1'($urandom) : 1'b1;
      dataIn    = dataValid ? curImg[idx] : 1'($urandom);
      if (dataValid && dataReady) idx++;
      step();
      budget++;
    end
    dataValid = 1'b0;
    checks++;
    if (idx !== NIN) begin
      errors++;
      $display("[TB] FAIL stream_accept: got %0d accepted beats, expected %0d", idx, NIN);
    end
  endtask

  task automatic runImage(input bit gaps, input bit junk, input string tag);
    int h0 = hidStarts;
    int o0 = outStarts;
    int v0 = validCount;
    int hv0 = holdViolations;
    int expPred = expectedClass();
    logic [NHID-1:0] expHid = expectedHidden();
    bit readyBad = 1'b0;
    bit seen = 1'b0;
    streamImage(gaps);
    for (int c = 0; c < 3000; c++) begin
      if (validOut === 1'b1) begin seen = 1'b1; break; end
      if (dataReady !== 1'b0) readyBad = 1'b1;
      if (junk) begin dataValid = 1'b1; dataIn = 1'($urandom); end
      step();
    end
    checks++;
    if (!seen) begin
      errors++;
      dataValid = 1'b0;
      $display("[TB] FAIL %s valid_timeout: got no valid_out, expected one", tag);
      return;
    end
    dataValid = 1'b0;
    checks++;
    if (readyBad) begin
      errors++;
      $display("[TB] FAIL %s ready_busy: got data_ready=1 while busy, expected 0", tag);
    end
    checks++;
    if (cycle - lastOutDoneCycle !== 2) begin
      errors++;
      $display("[TB] FAIL %s valid_latency: got %0d cycles, expected 2", tag, cycle - lastOutDoneCycle);
    end
    checks++;
    if (prediction !== 4'(expPred)) begin
      errors++;
      $display("[TB] FAIL %s prediction: got %0d, expected %0d", tag, prediction, expPred);
    end
    checks++;
    if (hidAct !== expHid) begin
      errors++;
      $display("[TB] FAIL %s hid_act: got %h, expected %h", tag, hidAct, expHid);
    end
    checks++;
    if (pixels !== curImg) begin
      errors++;
      $display("[TB] FAIL %s pixels: got %0d differing bits, expected 0", tag, bitDiff(pixels, curImg));
    end
    checks++;
    if (dataReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s ready_after: got %b, expected 1", tag, dataReady);
    end
    checks++;
    if (hidStarts - h0 !== NHID || outStarts - o0 !== NOUT) begin
      errors++;
      $display("[TB] FAIL %s mac_starts: got %0d/%0d, expected %0d/%0d", tag,
               hidStarts - h0, outStarts - o0, NHID, NOUT);
    end
    checks++;
    if (holdViolations !== hv0) begin
      errors++;
      $display("[TB] FAIL %s neuron_hold: got %0d changes, expected 0", tag, holdViolations - hv0);
    end
    step();
    checks++;
    if (validOut !== 1'b0 || validCount - v0 !== 1) begin
      errors++;
      $display("[TB] FAIL %s valid_pulse: got valid=%b count=%0d, expected 0 and 1", tag,
               validOut, validCount - v0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++;
    if (dataReady !== 1'b1 || validOut !== 1'b0 || macStart !== 1'b0 || macLayer !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got ready=%b valid=%b start=%b layer=%b, expected 1 0 0 0",
               dataReady, validOut, macStart, macLayer);
    end
    checks++;
    if (pixels !== '0 || hidAct !== '0 || prediction !== 4'd0 || macNeuron !== 6'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: got hid=%h pred=%0d neuron=%0d, expected all zero",
               hidAct, prediction, macNeuron);
    end
  endtask

  task automatic test_peak_class7();
    randomHidden();
    randomOutput(-100, 100);
    outScores[7] = 16'sd120;
    runImage(1'b0, 1'b0, "peak7");
  endtask

  task automatic test_tie();
    randomHidden();
    randomOutput(-200, 49);
    outScores[3] = 16'sd50;
    outScores[5] = 16'sd50;
    runImage(1'b0, 1'b0, "tie");
  endtask

  task automatic test_all_negative();
    randomHidden();
    randomOutput(-300, -9);
    outScores[9] = -16'sd5;
    runImage(1'b0, 1'b0, "negative");
  endtask

  task automatic test_hidden_sign();
    randomHidden();
    randomOutput(-500, 500);
    hidScores[0] = -16'sd1;
    hidScores[1] = 16'sd0;
    hidScores[2] = 16'sd1;
    runImage(1'b0, 1'b0, "hidsign");
    checks++;
    if (hidAct[2:0] !== 3'b110) begin
      errors++;
      $display("[TB] FAIL hid_sign_bits: got %b, expected 110", hidAct[2:0]);
    end
  endtask

  task automatic test_gapped_load();
    randomHidden();
    randomOutput(-1000, 1000);
    runImage(1'b1, 1'b1, "gapped");
  endtask

  task automatic test_reset_mid_run();
    int v0;
    bit found = 1'b0;
    bit busy = 1'b0;
    randomHidden();
    randomOutput(-100, 100);
    streamImage(1'b0);
    for (int c = 0; c < 200; c++) begin
      if (macStart === 1'b1 && macLayer === 1'b0 && macNeuron === 6'd2) begin found = 1'b1; break; end
      step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL abort_reach: got no hidden neuron 2 start, expected one");
    end
    step();
    v0 = validCount;
    rst = 1'b1;
    macEnable = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    checks++;
    if (dataReady !== 1'b1 || hidAct !== '0 || pixels !== '0 || prediction !== 4'd0) begin
      errors++;
      $display("[TB] FAIL abort_reset: got ready=%b hid=%h pred=%0d, expected 1 0 0",
               dataReady, hidAct, prediction);
    end
    injectReq++;
    for (int c = 0; c < 6; c++) begin
      if (dataReady !== 1'b1 || macStart !== 1'b0) busy = 1'b1;
      step();
    end
    checks++;
    if (busy || validCount !== v0) begin
      errors++;
      $display("[TB] FAIL abort_spurious: got busy=%b valids=%0d, expected 0 and 0", busy,
               validCount - v0);
    end
    macEnable = 1'b1;
    randomHidden();
    randomOutput(-100, 100);
    runImage(1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 2; n++) begin
      randomHidden();
      randomOutput(-32768, 32767);
      runImage(1'b0, 1'b0, "b2b");
    end
  endtask

  initial begin
    for (int j = 0; j < NHID; j++) hidScores[j] = '0;
    for (int k = 0; k < NOUT; k++) outScores[k] = '0;
    test_reset();
    test_peak_class7();
    test_tie();
    test_all_negative();
    test_hidden_sign();
    test_gapped_load();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
